gray_counter: RTL and testbench
===============================

Name: gray_counter

Overview:
- Registered Gray-code counter: keeps a binary count, increments on enable, drives the count and its Gray encoding (bin ^ (bin >> 1)) straight from flops.
- Intended as the pointer source for clock-domain-crossing FIFOs. Its Gray output is the value a gray-to-binary decoder on the far side converts back.
- Supports a synchronous load of a Gray value, converted to binary internally, so a pointer can be re-seeded from a synchronized remote pointer.

Parameters:
- DATA_WIDTH, default 16: counter width in bits (>= 1). Count range 0 .. 2^DATA_WIDTH-1.

Ports:
- clk  input  1  rising-edge clock.
- resetn  input  1  asynchronous active-low reset.
- en  input  1  advance the count by one this cycle.
- load  input  1  synchronous load request.
- load_gray  input  DATA_WIDTH  Gray-coded value to load when load=1.
- gray  output  DATA_WIDTH  registered Gray code of the current count.
- bin  output  DATA_WIDTH  registered binary count.
- wrap  output  1  registered one-cycle pulse: count went from terminal to 0, or to terminal in down mode.

Behaviour:
- Reset (resetn=0, asynchronous): bin=0, gray=0, wrap=0 immediately. These hold while resetn=0.
- Release is synchronous: the first active edge after resetn rises can update state.
- Priority on each rising edge: load > en > hold.
- load=1:
  - bin <= G2B(load_gray), gray <= load_gray (registered directly, not recomputed), wrap <= 0.
  - en is ignored that cycle.
  - G2B: b[N-1]=g[N-1]; b[i]=b[i+1]^g[i].
- en=1, load=0:
  - bin <= bin+1, modulo 2^DATA_WIDTH.
  - gray <= B2G(bin+1), computed from the next binary value so the gray flops change exactly one bit per increment.
  - wrap <= 1 iff bin was all-ones.
- Neither asserted: bin and gray hold, wrap <= 0.
- Latency: one clock from en/load to the updated outputs. wrap is aligned with the bin/gray update that wrapped.
- Invariant, every cycle outside reset: gray == bin ^ (bin >> 1).
- Consecutive gray values produced by en differ in exactly one bit, including across wrap.
- DATA_WIDTH=1:
  - gray == bin, and the count toggles 0/1.
  - wrap pulses on the 1->0 transition.
- Reset asserted mid-count clears everything asynchronously. There is no partial-update state.
- No combinational path from any input to any output.

Optional Feature:
- Macro: GRAY_COUNTER_DOWN_EN.
- Defined:
  - Adds input port dir (1 bit; 0=up, 1=down), sampled only when en=1 and load=0.
  - Down: bin <= bin-1 modulo 2^DATA_WIDTH, gray <= B2G(bin-1).
  - wrap pulses when bin was 0 and goes to all-ones.
  - Up behaviour is unchanged.
- Not defined: no dir port; the counter is up-only, exactly as above.

Decomposition:
- Package gray_pkg holds:
  - pure functions b2g and g2b, parameterized by width via a localparam in the caller, or written with a max-width constant GRAY_MAX_W=64 plus masking;
  - no typedefs beyond that.
- gray_counter instantiates no submodules. The only natural split is the stateless converters, which live in the package as functions rather than as a module.

Test Plan:
- DATA_WIDTH=4, reset then en=1 for 16 cycles:
  - gray steps 0000,0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000, then 0000;
  - wrap=1 only on the cycle gray returns to 0000;
  - every step has Hamming distance 1.
- Load with simultaneous en: load=1, en=1, load_gray=4'b1011 -> next cycle bin=4'd13, gray=4'b1011, wrap=0. Then en=1 -> bin=14, gray=4'b1001.
- Hold: en=0, load=0 for 5 cycles at bin=7 -> bin=7, gray=4'b0100 stable, wrap=0 throughout.
- Reset mid-operation:
  - resetn driven low between clock edges while bin=9 -> bin=0, gray=0, wrap=0 before the next edge;
  - en held high through release -> first edge after release gives bin=1, gray=0001.
- Invariant sweep, DATA_WIDTH=16: 10k random en/load/load_gray cycles -> gray == bin^(bin>>1) every cycle. An independent g2b model of gray matches bin.
- With GRAY_COUNTER_DOWN_EN, DATA_WIDTH=4, at bin=0, en=1, dir=1 -> bin=15, gray=1000, wrap=1. Next dir=1 -> bin=14, gray=1001, wrap=0.

Source files
------------

// File: rtl/gray_pkg.sv
// -----------------------------------------------------------------------------
// gray_pkg
// Stateless binary <-> Gray converters shared by the Gray counter.
//
// Both functions work on a fixed GRAY_MAX_W-bit container. Callers zero-extend
// their narrower operand into the container and truncate the result back to
// their own width. Zero upper bits do not change either conversion:
//   - b2g: the zero MSBs shift into zeros.
//   - g2b: each binary bit is the XOR of all Gray bits at or above it, and
//     zeros contribute nothing.
// Callers therefore never need to mask.
// -----------------------------------------------------------------------------
package gray_pkg;

    localparam int GRAY_MAX_W = 64;

    // Binary to reflected Gray code.
    function automatic logic [GRAY_MAX_W-1:0] b2g(input logic [GRAY_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Reflected Gray code to binary: b[N-1] = g[N-1], b[i] = b[i+1] ^ g[i].
    function automatic logic [GRAY_MAX_W-1:0] g2b(input logic [GRAY_MAX_W-1:0] g);
        logic [GRAY_MAX_W-1:0] b;
        b = '0;
        b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_counter.sv
// -----------------------------------------------------------------------------
// gray_counter
// Registered Gray-code counter intended as a CDC FIFO pointer source. It keeps a
// binary count and a Gray copy, and drives both straight from flops. The Gray
// flops are loaded with the Gray code of the *next* binary value, so they change
// exactly one bit per step and can be synchronized safely into another domain.
// A Gray value can be loaded synchronously, for example to re-seed from a
// synchronized remote pointer.
//
// Parameters:
//   DATA_WIDTH  counter width, 1 .. gray_pkg::GRAY_MAX_W (default 16)
//
// Ports:
//   clk        rising-edge clock
//   resetn     asynchronous active-low reset; clears bin, gray and wrap
//   en         advance the count by one this cycle
//   load       synchronous load; takes priority over en
//   load_gray  Gray-coded value captured when load=1
//   dir        (GRAY_COUNTER_DOWN_EN only) 0 = count up, 1 = count down
//   gray       registered Gray code of the count
//   bin        registered binary count
//   wrap       registered one-cycle pulse on terminal->0 (up) or 0->terminal (down)
//
// Optional build macro:
//   GRAY_COUNTER_DOWN_EN  adds the dir port and down counting. When it is not
//                         defined, the counter counts up only.
// -----------------------------------------------------------------------------
module gray_counter
    import gray_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  en,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_gray,
`ifdef GRAY_COUNTER_DOWN_EN
    input  logic                  dir,
`endif
    output logic [DATA_WIDTH-1:0] gray,
    output logic [DATA_WIDTH-1:0] bin,
    output logic                  wrap
);

    localparam logic [DATA_WIDTH-1:0] ONE_V = DATA_WIDTH'(1'b1);

    logic [DATA_WIDTH-1:0] bin_r;
    logic [DATA_WIDTH-1:0] gray_r;
    logic                  wrap_r;

    logic                  down_s;
    logic [DATA_WIDTH-1:0] step_bin_s;
    logic                  step_wrap_s;
    logic [GRAY_MAX_W-1:0] step_ext_s;
    logic [GRAY_MAX_W-1:0] load_ext_s;
    logic [DATA_WIDTH-1:0] step_gray_s;
    logic [DATA_WIDTH-1:0] load_bin_s;
    logic [DATA_WIDTH-1:0] bin_nxt_s;
    logic [DATA_WIDTH-1:0] gray_nxt_s;
    logic                  wrap_nxt_s;

    // Count direction: fixed to up unless the down option is built in.
    always_comb begin
        down_s = 1'b0;
`ifdef GRAY_COUNTER_DOWN_EN
        down_s = dir;
`endif
    end

    // Next binary value for a counting step, and whether that step wraps.
    always_comb begin
        step_bin_s  = bin_r;
        step_wrap_s = 1'b0;
        if (down_s) begin
            step_bin_s  = bin_r - ONE_V;
            step_wrap_s = ~|bin_r;
        end else begin
            step_bin_s  = bin_r + ONE_V;
            step_wrap_s = &bin_r;
        end
    end

    // Convert the stepped binary value to Gray, and the loaded Gray value to
    // binary. Each operand is zero-extended into the package's wide container.
    always_comb begin
        step_ext_s                   = '0;
        step_ext_s[DATA_WIDTH-1:0]   = step_bin_s;
        load_ext_s                   = '0;
        load_ext_s[DATA_WIDTH-1:0]   = load_gray;
        step_gray_s                  = DATA_WIDTH'(b2g(step_ext_s));
        load_bin_s                   = DATA_WIDTH'(g2b(load_ext_s));
    end

    // Select the next state with priority load > en > hold.
    // On a load, the Gray flops take load_gray as given rather than a
    // recomputed value.
    always_comb begin
        bin_nxt_s  = bin_r;
        gray_nxt_s = gray_r;
        wrap_nxt_s = 1'b0;
        if (load) begin
            bin_nxt_s  = load_bin_s;
            gray_nxt_s = load_gray;
            wrap_nxt_s = 1'b0;
        end else if (en) begin
            bin_nxt_s  = step_bin_s;
            gray_nxt_s = step_gray_s;
            wrap_nxt_s = step_wrap_s;
        end else begin
            bin_nxt_s  = bin_r;
            gray_nxt_s = gray_r;
            wrap_nxt_s = 1'b0;
        end
    end

    // State and output registers, cleared asynchronously by resetn.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bin_r  <= '0;
            gray_r <= '0;
            wrap_r <= 1'b0;
        end else begin
            bin_r  <= bin_nxt_s;
            gray_r <= gray_nxt_s;
            wrap_r <= wrap_nxt_s;
        end
    end

    assign bin  = bin_r;
    assign gray = gray_r;
    assign wrap = wrap_r;

endmodule

// File: tb/tb_gray_counter.sv
// -----------------------------------------------------------------------------
// tb_gray_counter
// Directed, table-driven bench for gray_counter.
//   - A 4-bit instance runs a vector table: full count cycle with wrap,
//     load-with-en, and hold.
//   - Hand-written sequences cover mid-count reset and, when built with
//     GRAY_COUNTER_DOWN_EN, down counting.
//   - A 16-bit instance runs a random en/load sweep against a bench model.
// -----------------------------------------------------------------------------
module tb_gray_counter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        en4, load4;
    logic [3:0]  lg4;
    logic [3:0]  gray4, bin4;
    logic        wrap4;
    logic        en16, load16;
    logic [15:0] lg16;
    logic [15:0] gray16, bin16;
    logic        wrap16;
`ifdef GRAY_COUNTER_DOWN_EN
    logic        dir4;
    logic        dir16;
`endif

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    gray_counter #(.DATA_WIDTH(4)) dut4 (
        .clk(clk), .resetn(resetn), .en(en4), .load(load4), .load_gray(lg4),
`ifdef GRAY_COUNTER_DOWN_EN
        .dir(dir4),
`endif
        .gray(gray4), .bin(bin4), .wrap(wrap4)
    );

    gray_counter #(.DATA_WIDTH(16)) dut16 (
        .clk(clk), .resetn(resetn), .en(en16), .load(load16), .load_gray(lg16),
`ifdef GRAY_COUNTER_DOWN_EN
        .dir(dir16),
`endif
        .gray(gray16), .bin(bin16), .wrap(wrap16)
    );

    typedef struct {
        logic       en;
        logic       load;
        logic [3:0] lg;
        logic [3:0] bin;
        logic [3:0] gray;
        logic       wrap;
        logic       step;   // counting step: also check the 1-bit Gray change
    } vec_t;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Gray to binary, written as XOR of all right shifts of the Gray value.
    function automatic logic [15:0] model_g2b(input logic [15:0] g);
        logic [15:0] b;
        b = g;
        for (int s = 1; s < 16; s++) b = b ^ (g >> s);
        return b;
    endfunction

    task automatic tick4(input logic e, input logic l, input logic [3:0] g);
        @(negedge clk);
        en4 = e; load4 = l; lg4 = g;
        @(posedge clk);
        #1;
    endtask

    vec_t        tbl[$];
    logic [3:0]  gseq[16];
    logic [3:0]  prev_gray;
    logic [15:0] mb;
    logic        mwrap;

    initial begin
        // Gray value after each of 16 increments from 0.
        gseq = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100, 4'b1100,
                 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000, 4'b0000};
        for (int i = 0; i < 16; i++)
            tbl.push_back('{1'b1, 1'b0, 4'h0, 4'((i + 1) % 16), gseq[i], (i == 15), 1'b1});
        tbl.push_back('{1'b1, 1'b1, 4'b1011, 4'd13, 4'b1011, 1'b0, 1'b0}); // load beats en
        tbl.push_back('{1'b1, 1'b0, 4'h0,    4'd14, 4'b1001, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 1'b1, 4'b0100, 4'd7,  4'b0100, 1'b0, 1'b0});
        for (int i = 0; i < 5; i++)
            tbl.push_back('{1'b0, 1'b0, 4'h0, 4'd7, 4'b0100, 1'b0, 1'b0});

        resetn = 1'b0;
        en4 = 1'b0; load4 = 1'b0; lg4 = 4'h0;
        en16 = 1'b0; load16 = 1'b0; lg16 = 16'h0;
`ifdef GRAY_COUNTER_DOWN_EN
        dir4 = 1'b0; dir16 = 1'b0;
`endif
        #1;
        check("reset_bin", bin4, 4'd0);
        check("reset_gray", gray4, 4'd0);
        check("reset_wrap", wrap4, 1'b0);
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;

        prev_gray = 4'b0000;
        for (int i = 0; i < tbl.size(); i++) begin
            tick4(tbl[i].en, tbl[i].load, tbl[i].lg);
            check($sformatf("tbl%0d_bin", i), bin4, tbl[i].bin);
            check($sformatf("tbl%0d_gray", i), gray4, tbl[i].gray);
            check($sformatf("tbl%0d_wrap", i), wrap4, tbl[i].wrap);
            if (tbl[i].step)
                check($sformatf("tbl%0d_hamming", i), 32'($countones(gray4 ^ prev_gray)), 32'd1);
            prev_gray = gray4;
        end

        // Reset mid-count: load 9 (Gray 1101), then assert resetn between edges.
        tick4(1'b0, 1'b1, 4'b1101);
        check("pre_rst_bin", bin4, 4'd9);
        en4 = 1'b1; load4 = 1'b0;
        #2 resetn = 1'b0;
        #1;
        check("async_rst_bin", bin4, 4'd0);
        check("async_rst_gray", gray4, 4'd0);
        check("async_rst_wrap", wrap4, 1'b0);
        @(posedge clk);
        #1;
        check("rst_hold_bin", bin4, 4'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        check("rel_bin", bin4, 4'd1);
        check("rel_gray", gray4, 4'b0001);
        check("rel_wrap", wrap4, 1'b0);

`ifdef GRAY_COUNTER_DOWN_EN
        // Down counting from 0 wraps to all-ones.
        @(negedge clk);
        resetn = 1'b0;
        en4 = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        dir4 = 1'b1;
        tick4(1'b1, 1'b0, 4'h0);
        check("down_wrap_bin", bin4, 4'd15);
        check("down_wrap_gray", gray4, 4'b1000);
        check("down_wrap_wrap", wrap4, 1'b1);
        tick4(1'b1, 1'b0, 4'h0);
        check("down2_bin", bin4, 4'd14);
        check("down2_gray", gray4, 4'b1001);
        check("down2_wrap", wrap4, 1'b0);
        dir4 = 1'b0;
        tick4(1'b1, 1'b0, 4'h0);
        check("up_again_bin", bin4, 4'd15);
        check("up_again_gray", gray4, 4'b1000);
        check("up_again_wrap", wrap4, 1'b0);
`endif
        en4 = 1'b0;

        // Random sweep on the 16-bit instance. It has been idle (en16=0) since
        // reset, so it starts at 0.
        mb = 16'd0;
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            en16   = 1'($urandom);
            load16 = ($urandom_range(0, 15) == 0);
            lg16   = 16'($urandom);
            mwrap  = 1'b0;
            if (load16) begin
                mb = model_g2b(lg16);
            end else if (en16) begin
                mwrap = (mb == 16'hFFFF);
                mb    = mb + 16'd1;
            end
            @(posedge clk);
            #1;
            check($sformatf("sweep%0d_bin", c), bin16, mb);
            check($sformatf("sweep%0d_inv", c), gray16, bin16 ^ (bin16 >> 1));
            check($sformatf("sweep%0d_g2b", c), model_g2b(gray16), mb);
            check($sformatf("sweep%0d_wrap", c), wrap16, mwrap);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
